// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolution end of branch prediction. Fetch-time predictions (direction and
// target) ride a shadow IF->ID->EX pipeline alongside the real instruction.
// In EX they are compared with the actual outcome. The unit drives:
//   - the predictor update strobe (conditional branches only),
//   - a combinational mispredict flag,
//   - a registered fetch redirect together with an IF/ID flush,
//   - saturating branch and mispredict statistics counters.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   mem_stall_i                 pipeline freeze; shadow slots and FSM hold
//   if_valid_i, if_pc_i         instruction currently in IF
//   if_pred_taken_i             predicted direction for if_pc_i
//   if_pred_target_i            predicted target for if_pc_i
//   ex_is_br_i, ex_is_jump_i    EX instruction class (cond branch / jal, jalr)
//   ex_br_en_i, ex_target_i     actual outcome and computed target in EX
//   pred_update_valid_o         comb: update predictor this cycle
//   pred_update_taken_o         comb: actual direction
//   mispredict_o                comb: EX prediction was wrong
//   redirect_valid_o            reg: load redirect_pc_o into fetch PC
//   redirect_pc_o               reg: correct next PC
//   flush_if_id_o               reg: squash IF and ID
//   br_count_o                  resolved conditional branches (saturating)
//   mispred_count_o             mispredicts of any kind (saturating)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_i,
    input  logic             if_pred_taken_i,
    input  logic [31:0]      if_pred_target_i,
    input  logic             ex_is_br_i,
    input  logic             ex_is_jump_i,
    input  logic             ex_br_en_i,
    input  logic [31:0]      ex_target_i,
    output logic             pred_update_valid_o,
    output logic             pred_update_taken_o,
    output logic             mispredict_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_if_id_o,
    output logic [CNT_W-1:0] br_count_o,
    output logic [CNT_W-1:0] mispred_count_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } slot_t;

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e           state_q, state_d;
    slot_t            id_q, id_d, ex_q, ex_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    logic             resolve;
    logic             is_cond;
    logic             wrong;
    logic [31:0]      seq_pc;
    logic [31:0]      correct_pc;

    // Outcome evaluation of the EX slot.
    always_comb begin
        resolve    = ex_q.valid & ~mem_stall_i & (state_q == StIdle);
        // A jump flag wins over the branch flag when both are set.
        is_cond    = ex_is_br_i & ~ex_is_jump_i;
        seq_pc     = ex_q.pc + 32'd4;  // wraps mod 2^32
        wrong      = 1'b0;
        correct_pc = seq_pc;
        if (ex_is_jump_i) begin
            wrong      = ~ex_q.pred_taken | (ex_q.pred_target != ex_target_i);
            correct_pc = ex_target_i;
        end else if (is_cond) begin
            wrong      = (ex_q.pred_taken != ex_br_en_i)
                       | (ex_q.pred_taken & ex_br_en_i & (ex_q.pred_target != ex_target_i));
            correct_pc = ex_br_en_i ? ex_target_i : seq_pc;
        end else begin
            // Non-control instruction: any taken prediction sent fetch astray.
            wrong = ex_q.pred_taken;
        end
    end

    assign mispredict_o        = resolve & wrong;
    assign pred_update_valid_o = resolve & is_cond;
    assign pred_update_taken_o = resolve & ex_br_en_i;

    assign redirect_valid_o = (state_q == StRedirect);
    assign flush_if_id_o    = (state_q == StRedirect);
    assign redirect_pc_o    = redirect_pc_q;
    assign br_count_o       = br_cnt_q;
    assign mispred_count_o  = mis_cnt_q;

    // Next-state: FSM, shadow pipeline, redirect PC and counters.
    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        ex_d          = ex_q;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        mis_cnt_d     = mis_cnt_q;

        if (pred_update_valid_o && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
        end
        if (mispredict_o && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end

        if (!mem_stall_i) begin
            unique case (state_q)
                StIdle: begin
                    if (mispredict_o) begin
                        // ID and EX hold wrong-path work; drop both.
                        state_d       = StRedirect;
                        redirect_pc_d = correct_pc;
                        id_d.valid    = 1'b0;
                        ex_d.valid    = 1'b0;
                    end else begin
                        ex_d = id_q;
                        id_d = '{valid:       if_valid_i,
                                 pc:          if_pc_i,
                                 pred_taken:  if_pred_taken_i,
                                 pred_target: if_pred_target_i};
                    end
                end
                StRedirect: begin
                    // IF is still on the wrong path this cycle; capture it invalid.
                    state_d = StIdle;
                    ex_d    = id_q;
                    id_d    = '{valid:       1'b0,
                                pc:          if_pc_i,
                                pred_taken:  if_pred_taken_i,
                                pred_target: if_pred_target_i};
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            id_q          <= '0;
            ex_q          <= '0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mis_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            ex_q          <= ex_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Self-checking bench for branch_resolve_unit (CNT_W = 4 so saturation is
// reachable). A behavioural model tracks the instructions in ID/EX and the
// pending redirect. Expectations come from the "predicted vs actual direction
// and target" rule. The model is checked on every cycle. Directed scenarios
// add literal expectations, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_stall;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic [31:0]      if_pred_target;
    logic             ex_is_br;
    logic             ex_is_jump;
    logic             ex_br_en;
    logic [31:0]      ex_target;
    logic             pred_update_valid;
    logic             pred_update_taken;
    logic             mispredict;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush_if_id;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_stall_i         (mem_stall),
        .if_valid_i          (if_valid),
        .if_pc_i             (if_pc),
        .if_pred_taken_i     (if_pred_taken),
        .if_pred_target_i    (if_pred_target),
        .ex_is_br_i          (ex_is_br),
        .ex_is_jump_i        (ex_is_jump),
        .ex_br_en_i          (ex_br_en),
        .ex_target_i         (ex_target),
        .pred_update_valid_o (pred_update_valid),
        .pred_update_taken_o (pred_update_taken),
        .mispredict_o        (mispredict),
        .redirect_valid_o    (redirect_valid),
        .redirect_pc_o       (redirect_pc),
        .flush_if_id_o       (flush_if_id),
        .br_count_o          (br_count),
        .mispred_count_o     (mispred_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tgt;
    } mslot_t;

    mslot_t      m_id, m_ex;
    bit          m_redir = 1'b0;
    logic [31:0] m_rpc = '0;
    int          m_br = 0;
    int          m_mis = 0;
    bit          m_known = 1'b0;

    // Resolution of the instruction in EX: it was mispredicted if fetch guessed
    // the wrong direction, or guessed taken but to the wrong place.
    task automatic m_eval(output bit res, output bit cond, output bit mis,
                          output logic [31:0] cpc);
        bit act_taken;
        res  = m_ex.v && !mem_stall && !m_redir;
        cond = ex_is_br && !ex_is_jump;
        if (ex_is_jump) begin
            act_taken = 1'b1;
            cpc       = ex_target;
        end else if (cond) begin
            act_taken = ex_br_en;
            cpc       = ex_br_en ? ex_target : 32'(m_ex.pc + 32'd4);
        end else begin
            act_taken = 1'b0;
            cpc       = 32'(m_ex.pc + 32'd4);
        end
        mis = res && ((m_ex.pt != act_taken) || (act_taken && (m_ex.tgt != cpc)));
    endtask

    always @(posedge clk) begin
        bit res, cond, mis;
        logic [31:0] cpc;
        m_eval(res, cond, mis, cpc);
        if (rst) begin
            m_id.v  = 1'b0;
            m_ex.v  = 1'b0;
            m_redir = 1'b0;
            m_rpc   = '0;
            m_br    = 0;
            m_mis   = 0;
            m_known = 1'b1;
        end else begin
            if (res && cond && m_br < MAXC) m_br++;
            if (mis && m_mis < MAXC) m_mis++;
            if (!mem_stall) begin
                if (m_redir) begin
                    m_redir = 1'b0;
                    m_ex    = m_id;
                    m_id    = '{1'b0, if_pc, if_pred_taken, if_pred_target};
                end else if (mis) begin
                    m_redir = 1'b1;
                    m_rpc   = cpc;
                    m_id.v  = 1'b0;
                    m_ex.v  = 1'b0;
                end else begin
                    m_ex = m_id;
                    m_id = '{if_valid, if_pc, if_pred_taken, if_pred_target};
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        bit res, cond, mis;
        logic [31:0] cpc;
        #2;
        if (m_known) begin
            m_eval(res, cond, mis, cpc);
            chk("m_pred_update_valid", pred_update_valid, res && cond);
            chk("m_pred_update_taken", pred_update_taken, res && ex_br_en);
            chk("m_mispredict", mispredict, mis);
            chk("m_redirect_valid", redirect_valid, m_redir);
            chk("m_flush_if_id", flush_if_id, m_redir);
            chk("m_redirect_pc", redirect_pc, m_rpc);
            chk("m_br_count", br_count, m_br);
            chk("m_mispred_count", mispred_count, m_mis);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit st, input bit iv, input logic [31:0] pc, input bit pt,
                         input logic [31:0] tg, input bit br, input bit j, input bit be,
                         input logic [31:0] et);
        @(negedge clk);
        rst            = 1'b0;
        mem_stall      = st;
        if_valid       = iv;
        if_pc          = pc;
        if_pred_taken  = pt;
        if_pred_target = tg;
        ex_is_br       = br;
        ex_is_jump     = j;
        ex_br_en       = be;
        ex_target      = et;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_stall = 1'b0;
        if_valid  = 1'b0;
        ex_is_br  = 1'b0;
        ex_is_jump = 1'b0;
        ex_br_en  = 1'b0;
    endtask

    logic [31:0] pcs [4];
    logic [31:0] tgts [3];

    initial begin
        rst = 1'b1; mem_stall = 1'b0; if_valid = 1'b0; if_pc = '0;
        if_pred_taken = 1'b0; if_pred_target = '0; ex_is_br = 1'b0;
        ex_is_jump = 1'b0; ex_br_en = 1'b0; ex_target = '0;

        // 1: reset state
        do_reset();
        idle(); #3;
        chk("t1_redirect_valid", redirect_valid, 0);
        chk("t1_flush", flush_if_id, 0);
        chk("t1_redirect_pc", redirect_pc, 0);
        chk("t1_mispredict", mispredict, 0);
        chk("t1_puv", pred_update_valid, 0);
        chk("t1_br_count", br_count, 0);
        chk("t1_mis_count", mispred_count, 0);

        // 2: correctly predicted taken branch
        do_reset();
        drive(0, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h200); #3;
        chk("t2_puv", pred_update_valid, 1);
        chk("t2_taken", pred_update_taken, 1);
        chk("t2_mispredict", mispredict, 0);
        idle(); #3;
        chk("t2_redirect_valid", redirect_valid, 0);
        chk("t2_br_count", br_count, 1);
        chk("t2_mis_count", mispred_count, 0);

        // 3: predicted not-taken, actually taken, resolved after a stall
        do_reset();
        drive(0, 1, 32'h100, 0, 32'h0, 0, 0, 0, 0);
        idle();
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 1, 0, 1, 32'h180); #3;
            chk("t3_stall_mispredict", mispredict, 0);
            chk("t3_stall_puv", pred_update_valid, 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h180); #3;
        chk("t3_mispredict", mispredict, 1);
        chk("t3_puv", pred_update_valid, 1);
        idle(); #3;
        chk("t3_redirect_valid", redirect_valid, 1);
        chk("t3_flush", flush_if_id, 1);
        chk("t3_redirect_pc", redirect_pc, 32'h180);
        chk("t3_br_count", br_count, 1);
        chk("t3_mis_count", mispred_count, 1);
        idle(); #3;
        chk("t3_redirect_done", redirect_valid, 0);

        // 4: jal with wrong predicted target
        do_reset();
        drive(0, 1, 32'h300, 1, 32'h400, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h404); #3;
        chk("t4_mispredict", mispredict, 1);
        chk("t4_puv", pred_update_valid, 0);
        idle(); #3;
        chk("t4_redirect_valid", redirect_valid, 1);
        chk("t4_redirect_pc", redirect_pc, 32'h404);
        chk("t4_br_count", br_count, 0);
        chk("t4_mis_count", mispred_count, 1);

        // 5: non-control predicted taken at top of memory; PC wraps to 0
        do_reset();
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h8, 0, 0, 0, 0);
        drive(0, 1, 32'h10, 1, 32'h40, 0, 0, 0, 0);
        drive(0, 1, 32'h14, 1, 32'h50, 0, 0, 0, 0); #3;
        chk("t5_mispredict", mispredict, 1);
        drive(1, 1, 32'h18, 1, 32'h60, 0, 0, 0, 0); #3;
        chk("t5_redirect_valid", redirect_valid, 1);
        chk("t5_redirect_pc", redirect_pc, 32'h0);
        drive(1, 1, 32'h18, 1, 32'h60, 0, 0, 0, 0); #3;
        chk("t5_hold", redirect_valid, 1);
        drive(0, 1, 32'h1c, 1, 32'h70, 0, 0, 0, 0); #3;
        chk("t5_release", redirect_valid, 1);
        repeat (4) begin
            idle(); #3;
            chk("t5_wrong_path", mispredict, 0);
        end
        chk("t5_redirect_done", redirect_valid, 0);
        chk("t5_mis_count", mispred_count, 1);

        // 6: saturation, then reset in the middle of a redirect
        do_reset();
        repeat (20) begin
            drive(0, 1, 32'h1000, 0, 32'h0, 0, 0, 0, 0);
            idle();
            drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h2000);
            idle();
        end
        idle(); #3;
        chk("t6_br_sat", br_count, 4'hF);
        chk("t6_mis_sat", mispred_count, 4'hF);
        drive(0, 1, 32'h1000, 0, 32'h0, 0, 0, 0, 0);
        idle();
        drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h2000);
        do_reset(); #3;
        chk("t6_mid_redirect", redirect_valid, 1);
        idle(); #3;
        chk("t6_reset_redirect", redirect_valid, 0);
        chk("t6_reset_br", br_count, 0);
        chk("t6_reset_mis", mispred_count, 0);

        // Randomized phase
        pcs[0] = 32'h100; pcs[1] = 32'h1FC; pcs[2] = 32'hFFFF_FFFC; pcs[3] = 32'h200;
        tgts[0] = 32'h100; tgts[1] = 32'h200; tgts[2] = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 99) == 0);
            mem_stall      = ($urandom_range(0, 3) == 0);
            if_valid       = ($urandom_range(0, 9) < 7);
            if_pc          = pcs[$urandom_range(0, 3)];
            if_pred_taken  = 1'($urandom_range(0, 1));
            if_pred_target = tgts[$urandom_range(0, 2)];
            ex_is_br       = 1'($urandom_range(0, 1));
            ex_is_jump     = ($urandom_range(0, 3) == 0);
            ex_br_en       = 1'($urandom_range(0, 1));
            ex_target      = tgts[$urandom_range(0, 2)];
        end
        idle();
        idle(); #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
